// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: fills and hunts on the received stream,
// then flywheels its own LFSR while locked and counts bit errors against it.
module prbs_checker #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
  parameter int              LOCK_COUNT = 16,
  parameter int              WINDOW     = 64,
  parameter int              ERR_THRESH = 4,
  parameter int              ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 lock_lost
);

  // state  | meaning
  // FILL   | loading WIDTH received bits into the shift register
  // HUNT   | predicting each bit from received history, counting a run of matches
  // LOCKED | flywheel on own predictions, counting errors per window
  typedef enum logic [1:0] {FILL, HUNT, LOCKED} state_t;

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(ERR_THRESH + 1);

  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] THRESH     = EW'(ERR_THRESH);

  state_t               state, state_d;
  logic [WIDTH-1:0]     s, s_d, s_rx;
  logic [FW-1:0]        fill_cnt, fill_d;
  logic [MW-1:0]        match_cnt, match_d;
  logic [WW-1:0]        win_cnt, win_d;
  logic [EW-1:0]        win_err, werr_d, werr_base;
  logic [ERR_CNT_W-1:0] cnt_d;
  logic                 pred, err, pulse_d, lost_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      s         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      s         <= s_d;
      fill_cnt  <= fill_d;
      match_cnt <= match_d;
      win_cnt   <= win_d;
      win_err   <= werr_d;
      err_count <= cnt_d;
      err_pulse <= pulse_d;
      lock_lost <= lost_d;
      locked    <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d   = state;
    s_d       = s;
    fill_d    = fill_cnt;
    match_d   = match_cnt;
    win_d     = win_cnt;
    werr_d    = win_err;
    cnt_d     = err_count;
    pulse_d   = 1'b0;
    lost_d    = 1'b0;
    err       = 1'b0;
    werr_base = win_err;
    pred      = ^(s & TAPS);
    s_rx      = {s[WIDTH-2:0], bit_in};

    if (bit_valid) begin
      case (state)
        FILL: begin
          s_d = s_rx;
          if (fill_cnt == FILL_LAST) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_cnt + 1'b1;
          end
        end
        HUNT: begin
          s_d = s_rx;
          // an all-zero register predicts zeros forever, so it must never earn lock
          if (s_rx == '0 || bit_in != pred) begin
            match_d = '0;
          end else if (match_cnt == MATCH_LAST) begin
            state_d = LOCKED;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_cnt + 1'b1;
          end
        end
        LOCKED: begin
          s_d       = {s[WIDTH-2:0], pred};
          err       = bit_in ^ pred;
          win_d     = (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
          werr_base = (win_cnt == '0) ? '0 : win_err;
          werr_d    = werr_base + EW'(err);
          pulse_d   = err;
          if (err && err_count != '1) cnt_d = err_count + 1'b1;
          if (err && werr_d == THRESH) begin
            state_d = FILL;
            s_d     = '0;
            fill_d  = '0;
            lost_d  = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end

    if (clr_cnt) cnt_d = '0;
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed-sequence bench with randomized error placement, checked every cycle
// against a queue-based behavioural model of the checker.
module tb_prbs_checker;
  localparam int          W   = 8;
  localparam logic [7:0]  TP  = 8'hB8;
  localparam int          LC  = 16;
  localparam int          WIN = 64;
  localparam int          TH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bit_in = 1'b0, bit_valid = 1'b0, clr_cnt = 1'b0;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_count;
  logic        locked_s, err_pulse_s, lock_lost_s;
  logic [3:0]  err_count_s;

  prbs_checker dut (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .lock_lost(lock_lost));

  prbs_checker #(.ERR_CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .lock_lost(lock_lost_s));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model: mode 0 = fill, 1 = hunt, 2 = locked
  bit mq[$];
  int m_mode, m_fill, m_run, m_k, m_win, m_werr, m_cnt, m_cnt_s;
  bit m_pulse, m_lost;

  logic [7:0] g;
  int vcount = 0, pulses = 0, losts = 0, lock_vc = -1, loss_vc = -1;
  bit prev_locked = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_pred();
    bit p = 0;
    for (int i = 0; i < W; i++) if (TP[i]) p ^= mq[i];
    return p;
  endfunction

  task automatic m_zero_reg();
    mq.delete();
    for (int i = 0; i < W; i++) mq.push_back(1'b0);
  endtask

  task automatic m_reset();
    m_zero_reg();
    m_mode = 0; m_fill = 0; m_run = 0; m_k = 0; m_win = 0; m_werr = 0;
    m_cnt = 0; m_cnt_s = 0; m_pulse = 0; m_lost = 0;
  endtask

  task automatic m_shift(bit x);
    mq.push_front(x);
    void'(mq.pop_back());
  endtask

  task automatic m_step(bit b, bit v, bit c);
    bit p;
    int ones;
    m_pulse = 0; m_lost = 0;
    if (v) begin
      case (m_mode)
        0: begin
          m_shift(b);
          m_fill++;
          if (m_fill == W) begin m_mode = 1; m_run = 0; end
        end
        1: begin
          p = m_pred();
          m_shift(b);
          m_run = (b == p) ? m_run + 1 : 0;
          ones = 0;
          foreach (mq[i]) ones += int'(mq[i]);
          if (ones == 0) m_run = 0;
          if (m_run == LC) begin m_mode = 2; m_k = 0; m_win = 0; m_werr = 0; end
        end
        default: begin
          p = m_pred();
          m_shift(p);
          if (m_k / WIN != m_win) begin m_win = m_k / WIN; m_werr = 0; end
          m_k++;
          if (b != p) begin
            m_pulse = 1;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
            m_werr++;
            if (m_werr == TH) begin
              m_mode = 0; m_fill = 0; m_run = 0; m_zero_reg(); m_lost = 1;
            end
          end
        end
      endcase
    end
    if (c) begin m_cnt = 0; m_cnt_s = 0; end
  endtask

  task automatic check_all();
    chk("locked", 32'(locked), 32'(m_mode == 2));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    chk("err_count_w4", 32'(err_count_s), 32'(m_cnt_s));
  endtask

  function automatic bit gen_next();
    bit x = ^(g & TP);
    g = {g[6:0], x};
    return x;
  endfunction

  task automatic step(bit b, bit v, bit c);
    bit_in = b; bit_valid = v; clr_cnt = c;
    @(posedge clk);
    m_step(b, v, c);
    @(negedge clk);
    check_all();
    if (v) vcount++;
    if (err_pulse === 1'b1) pulses++;
    if (lock_lost === 1'b1) begin losts++; loss_vc = vcount; end
    if (locked === 1'b1 && !prev_locked) lock_vc = vcount;
    prev_locked = (locked === 1'b1);
  endtask

  task automatic send(bit flip, bit c);
    bit x = gen_next();
    step(x ^ flip, 1'b1, c);
  endtask

  task automatic do_reset();
    bit_valid = 0; clr_cnt = 0;
    reset = 0;
    m_reset();
    @(negedge clk);
    check_all();
    reset = 1;
    prev_locked = 0;
  endtask

  task automatic align_window();
    for (int n = 0; n < WIN && (m_k % WIN) != 0; n++) send(1'b0, 1'b0);
  endtask

  initial begin
    int p0, l0, cnt, lock_cyc, v0, a, b, c;
    bit [27:0] mask;

    // T1: clean stream from seed 01
    g = 8'h01;
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      send(1'b0, 1'b0);
      if (i == 23) chk("t1_not_locked_at_23", 32'(locked), 32'd0);
    end
    chk("t1_locked_at_24", 32'(locked), 32'd1);
    p0 = pulses;
    repeat (2000) send(1'b0, 1'b0);
    chk("t1_no_pulses", 32'(pulses - p0), 32'd0);
    chk("t1_count_zero", 32'(err_count), 32'd0);

    // T2: single flipped bit
    repeat ($urandom_range(0, 30)) send(1'b0, 1'b0);
    p0 = pulses;
    repeat (99) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    repeat (500) send(1'b0, 1'b0);
    chk("t2_one_pulse", 32'(pulses - p0), 32'd1);
    chk("t2_count", 32'(err_count), 32'd1);
    chk("t2_still_locked", 32'(locked), 32'd1);

    // T3: four errors inside 20 bits of one window
    send(1'b0, 1'b1);
    align_window();
    mask = '0;
    cnt = 0;
    while (cnt < 4) begin
      a = $urandom_range(8, 27);
      if (!mask[a]) begin mask[a] = 1'b1; cnt++; end
    end
    l0 = losts;
    lock_vc = -1;
    for (int j = 0; j < 28; j++) send(mask[j], 1'b0);
    chk("t3_lock_lost_once", 32'(losts - l0), 32'd1);
    chk("t3_unlocked", 32'(locked), 32'd0);
    chk("t3_count", 32'(err_count), 32'd4);
    for (int n = 0; n < 100 && lock_vc < 0; n++) send(1'b0, 1'b0);
    chk("t3_relock_bits", 32'(lock_vc - loss_vc), 32'd24);

    // T4: three errors per window for ten windows
    send(1'b0, 1'b1);
    align_window();
    l0 = losts;
    for (int w = 0; w < 10; w++) begin
      a = $urandom_range(5, 20);
      b = $urandom_range(25, 40);
      c = $urandom_range(45, 58);
      for (int j = 0; j < WIN; j++) send(j == a || j == b || j == c, 1'b0);
    end
    chk("t4_still_locked", 32'(locked), 32'd1);
    chk("t4_no_loss", 32'(losts - l0), 32'd0);
    chk("t4_count", 32'(err_count), 32'd30);

    do_reset();
    cnt = 0;
    repeat (1000) begin
      step(1'b0, 1'b1, 1'b0);
      if (locked !== 1'b0) cnt++;
    end
    chk("t4_zero_never_locks", 32'(cnt), 32'd0);

    // T5: bit_valid toggling
    g = 8'h01;
    do_reset();
    lock_cyc = -1;
    for (int cy = 1; cy <= 100 && lock_cyc < 0; cy++) begin
      if (cy % 2 == 1) send(1'b0, 1'b0);
      else step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (locked === 1'b1) lock_cyc = cy;
    end
    chk("t5_lock_cycle", 32'(lock_cyc), 32'd47);
    send(1'b0, 1'b1);
    for (int e = 0; e < 20; e++) begin
      repeat ($urandom_range(66, 80)) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
    end
    send(1'b0, 1'b0);
    chk("t5_sat_w4", 32'(err_count_s), 32'd15);
    chk("t5_count_w16", 32'(err_count), 32'd20);
    send(1'b1, 1'b1);
    chk("t5_clr_priority", 32'(err_count), 32'd0);
    chk("t5_clr_priority_w4", 32'(err_count_s), 32'd0);
    chk("t5_clr_edge_pulse", 32'(err_pulse), 32'd1);

    // T6: async reset between edges while locked
    repeat (70) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    repeat (5) send(1'b0, 1'b0);
    chk("t6_pre_count", 32'(err_count), 32'd1);
    #1 reset = 0;
    #1;
    chk("t6_async_locked", 32'(locked), 32'd0);
    chk("t6_async_count", 32'(err_count), 32'd0);
    chk("t6_async_pulse", 32'(err_pulse), 32'd0);
    chk("t6_async_lost", 32'(lock_lost), 32'd0);
    m_reset();
    bit_valid = 0;
    @(negedge clk);
    reset = 1;
    prev_locked = 0;
    lock_vc = -1;
    v0 = vcount;
    for (int n = 0; n < 100 && lock_vc < 0; n++) send(1'b0, 1'b0);
    chk("t6_relock_bits", 32'(lock_vc - v0), 32'd24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
